// File: rtl/puf_pkg.sv
// Shared types and helpers for the RO-PUF response engine.
// State encoding, cycle-counter sizing and mux select arithmetic.
package puf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    COUNT,
    COMPARE,
    DONE
  } state_t;

  function automatic int cyc_w(int window, int settle);
    int m;
    m = (window > settle) ? window : settle;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

  function automatic int unsigned eff_step(int unsigned s);
    return (s == 0) ? 1 : s;
  endfunction

  function automatic int unsigned sel_add(
    int unsigned a,
    int unsigned b,
    int unsigned w
  );
    return (a + b) & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/puf_edge_counter.sv
// Rising-edge counter for one asynchronous ring oscillator.
// Two-flop synchroniser, edge detect, saturating count.
module puf_edge_counter #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ro,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic s1, s2, s3;
  logic rise;

  assign rise = s2 & ~s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      s3  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= ro;
      s2 <= s1;
      s3 <= s2;
      if (clr)
        cnt <= '0;
      else if (en && rise && (cnt != '1))
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/puf_response_engine.sv
// RO-PUF measurement sequencer: settle, count, compare per response bit.
// Define PUF_MARGIN_EN to derive resp_mask from the count difference.
module puf_response_engine
  import puf_pkg::*;
#(
  parameter int NUM_RO_LOG2 = 3,
  parameter int RESP_BITS   = 8,
  parameter int WINDOW      = 256,
  parameter int SETTLE_CYC  = 4,
  parameter int CNT_W       = 10,
  parameter int MARGIN      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     start,
  input  logic [2*NUM_RO_LOG2-1:0] challenge,
  input  logic                     ro_a,
  input  logic                     ro_b,
  output logic                     osc_en,
  output logic [NUM_RO_LOG2-1:0]   sel_a,
  output logic [NUM_RO_LOG2-1:0]   sel_b,
  output logic                     busy,
  output logic [RESP_BITS-1:0]     resp,
  output logic [RESP_BITS-1:0]     resp_mask,
  output logic                     resp_valid
);

  localparam int SW = NUM_RO_LOG2;
  localparam int CW = cyc_w(WINDOW, SETTLE_CYC);
  localparam int KW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

  state_t               state;
  logic [CW-1:0]        cyc;
  logic [KW-1:0]        k;
  logic [SW-1:0]        base;
  logic [SW-1:0]        step;
  logic [RESP_BITS-1:0] resp_sr;
  logic [RESP_BITS-1:0] mask_sr;
  logic [CNT_W-1:0]     cnt_a;
  logic [CNT_W-1:0]     cnt_b;
  logic                 clr;
  logic                 cnt_en;
  logic                 bit_r;
  logic                 bit_m;
  logic [SW-1:0]        b_use;
  logic [SW-1:0]        s_use;
  int unsigned          k_use;
  logic [SW-1:0]        nxt_a;
  logic [SW-1:0]        nxt_b;

  assign clr    = (state == IDLE) || (state == SETTLE);
  assign cnt_en = (state == COUNT);

  puf_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk(clk), .rst_n(rst_n), .ro(ro_a),
    .clr(clr), .en(cnt_en), .cnt(cnt_a)
  );

  puf_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk(clk), .rst_n(rst_n), .ro(ro_b),
    .clr(clr), .en(cnt_en), .cnt(cnt_b)
  );

  // Selects for the bit about to enter SETTLE
  always_comb begin
    b_use = base;
    s_use = step;
    k_use = 32'(k) + 32'd1;
    if (state == IDLE) begin
      b_use = challenge[SW-1:0];
      s_use = challenge[2*SW-1:SW];
      k_use = 32'd0;
    end
    nxt_a = SW'(sel_add(32'(b_use), k_use, SW));
    nxt_b = SW'(sel_add(32'(nxt_a), eff_step(32'(s_use)), SW));
  end

  assign bit_r = cnt_a > cnt_b;

`ifdef PUF_MARGIN_EN
  logic [CNT_W-1:0] diff;
  assign diff  = bit_r ? (cnt_a - cnt_b) : (cnt_b - cnt_a);
  assign bit_m = 32'(diff) >= MARGIN;
`else
  assign bit_m = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cyc        <= '0;
      k          <= '0;
      base       <= '0;
      step       <= '0;
      osc_en     <= 1'b0;
      sel_a      <= '0;
      sel_b      <= '0;
      busy       <= 1'b0;
      resp       <= '0;
      resp_mask  <= '1;
      resp_valid <= 1'b0;
      resp_sr    <= '0;
      mask_sr    <= '1;
    end else begin
      resp_valid <= 1'b0;
      if (!ena) begin
        state  <= IDLE;
        osc_en <= 1'b0;
        busy   <= 1'b0;
        cyc    <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state  <= SETTLE;
              base   <= challenge[SW-1:0];
              step   <= challenge[2*SW-1:SW];
              k      <= '0;
              cyc    <= '0;
              osc_en <= 1'b1;
              busy   <= 1'b1;
              sel_a  <= nxt_a;
              sel_b  <= nxt_b;
            end
          end
          SETTLE: begin
            if (cyc == CW'(SETTLE_CYC - 1)) begin
              state <= COUNT;
              cyc   <= '0;
            end else begin
              cyc <= cyc + 1'b1;
            end
          end
          COUNT: begin
            if (cyc == CW'(WINDOW - 1)) begin
              state  <= COMPARE;
              cyc    <= '0;
              osc_en <= 1'b0;
            end else begin
              cyc <= cyc + 1'b1;
            end
          end
          COMPARE: begin
            resp_sr <= {bit_r, resp_sr[RESP_BITS-1:1]};
            mask_sr <= {bit_m, mask_sr[RESP_BITS-1:1]};
            if (k == KW'(RESP_BITS - 1)) begin
              state <= DONE;
            end else begin
              state  <= SETTLE;
              k      <= k + 1'b1;
              osc_en <= 1'b1;
              sel_a  <= nxt_a;
              sel_b  <= nxt_b;
            end
          end
          DONE: begin
            resp       <= resp_sr;
            resp_mask  <= mask_sr;
            resp_valid <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_puf_response_engine.sv
// Directed bench for puf_response_engine with time-derived oscillators.
// Table of challenge runs plus abort, reset, held-start and saturation cases.
module tb_puf_response_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena;
  logic       start;
  logic [5:0] challenge;
  logic       ro_a, ro_b;
  logic       osc_en;
  logic [2:0] sel_a, sel_b;
  logic       busy;
  logic [7:0] resp, resp_mask;
  logic       resp_valid;

  logic       start2;
  logic       sro_a, sro_b;
  logic       osc_en2;
  logic [2:0] sel_a2, sel_b2;
  logic       busy2;
  logic [1:0] resp2, resp_mask2;
  logic       resp_valid2;

  int checks = 0;
  int failures = 0;

  // Oscillator periods in clk cycles; 0 = derived from the mux select
  int     pa, pb;
  longint t;
  int     qa, qb;

  always #5 clk = ~clk;

  always #1 begin
    t = $time + 3;
    qa = (pa != 0) ? pa : (sel_a[0] ? 6 : 4);
    qb = (pb != 0) ? pb : (sel_b[0] ? 6 : 4);
    ro_a  = ((t / (qa * 5)) % 2) == 0;
    ro_b  = ((t / (qb * 5)) % 2) == 0;
    sro_a = ((t / 10) % 2) == 0;
    sro_b = ((t / 30) % 2) == 0;
  end

  puf_response_engine #(
    .NUM_RO_LOG2(3), .RESP_BITS(8), .WINDOW(48),
    .SETTLE_CYC(4), .CNT_W(10), .MARGIN(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .challenge(challenge), .ro_a(ro_a), .ro_b(ro_b),
    .osc_en(osc_en), .sel_a(sel_a), .sel_b(sel_b), .busy(busy),
    .resp(resp), .resp_mask(resp_mask), .resp_valid(resp_valid)
  );

  puf_response_engine #(
    .NUM_RO_LOG2(3), .RESP_BITS(2), .WINDOW(64),
    .SETTLE_CYC(4), .CNT_W(4), .MARGIN(4)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start2),
    .challenge(6'h08), .ro_a(sro_a), .ro_b(sro_b),
    .osc_en(osc_en2), .sel_a(sel_a2), .sel_b(sel_b2), .busy(busy2),
    .resp(resp2), .resp_mask(resp_mask2), .resp_valid(resp_valid2)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_mask(input bit tie);
`ifdef PUF_MARGIN_EN
    return tie ? 8'h00 : 8'hFF;
`else
    return 8'hFF;
`endif
  endfunction

  task automatic run(input string tag, input logic [5:0] ch,
                     input logic [7:0] er, input logic [7:0] em,
                     input logic [2:0] sa, input logic [2:0] sb);
    int n;
    @(negedge clk);
    challenge = ch;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 1);
    check({tag, "_osc_en"}, 32'(osc_en), 1);
    check({tag, "_sel_a"}, 32'(sel_a), 32'(sa));
    check({tag, "_sel_b"}, 32'(sel_b), 32'(sb));
    n = 0;
    while (!resp_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 425);
    check({tag, "_resp"}, 32'(resp), 32'(er));
    check({tag, "_mask"}, 32'(resp_mask), 32'(em));
    check({tag, "_busy_off"}, 32'(busy), 0);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(resp_valid), 0);
  endtask

  typedef struct {
    int         pa;
    int         pb;
    logic [5:0] ch;
    logic [7:0] er;
    logic [2:0] sa;
    logic [2:0] sb;
    bit         tie;
  } vec_t;

  vec_t v[6];

  initial begin
    int n, first, pulses;
    logic [7:0] prev_r, prev_m;

    v[0] = '{4, 6, 6'h08, 8'hFF, 3'd0, 3'd1, 1'b0};
    v[1] = '{6, 4, 6'h08, 8'h00, 3'd0, 3'd1, 1'b0};
    v[2] = '{4, 4, 6'h08, 8'h00, 3'd0, 3'd1, 1'b1};
    v[3] = '{0, 0, 6'h03, 8'hAA, 3'd3, 3'd4, 1'b0};
    v[4] = '{0, 0, 6'h18, 8'h55, 3'd0, 3'd3, 1'b0};
    v[5] = '{0, 0, 6'h16, 8'h00, 3'd6, 3'd0, 1'b1};

    ena = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    challenge = '0;
    pa = 4;
    pb = 6;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("rst_osc_en", 32'(osc_en), 0);
    check("rst_sel_a", 32'(sel_a), 0);
    check("rst_sel_b", 32'(sel_b), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_resp", 32'(resp), 0);
    check("rst_mask", 32'(resp_mask), 32'hFF);
    check("rst_valid", 32'(resp_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      pa = v[i].pa;
      pb = v[i].pb;
      run($sformatf("vec%0d", i), v[i].ch, v[i].er,
          exp_mask(v[i].tie), v[i].sa, v[i].sb);
    end
    prev_r = v[5].er;
    prev_m = exp_mask(v[5].tie);

    // ena dropped during COUNT of bit 5
    pa = 4;
    pb = 6;
    @(negedge clk);
    challenge = 6'h08;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5 * 53 + 4 + 20 - 1) @(negedge clk);
    check("abort_pre_osc", 32'(osc_en), 1);
    ena = 1'b0;
    @(negedge clk);
    check("abort_osc_en", 32'(osc_en), 0);
    check("abort_busy", 32'(busy), 0);
    ena = 1'b1;
    pulses = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    check("abort_no_valid", pulses, 0);
    check("abort_resp_held", 32'(resp), 32'(prev_r));
    check("abort_mask_held", 32'(resp_mask), 32'(prev_m));

    // reset mid-COUNT, then a clean rerun
    run("pre_rst", 6'h08, 8'hFF, exp_mask(1'b0), 3'd0, 3'd1);
    @(negedge clk);
    challenge = 6'h0D;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_osc_en", 32'(osc_en), 0);
    check("mid_rst_sel_a", 32'(sel_a), 0);
    check("mid_rst_sel_b", 32'(sel_b), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_resp", 32'(resp), 0);
    check("mid_rst_mask", 32'(resp_mask), 32'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    run("post_rst", 6'h08, 8'hFF, exp_mask(1'b0), 3'd0, 3'd1);

    // start held high across most of the run
    @(negedge clk);
    challenge = 6'h08;
    start = 1'b1;
    first = -1;
    pulses = 0;
    for (int i = 1; i <= 1100; i++) begin
      @(negedge clk);
      if (i == 300) start = 1'b0;
      if (resp_valid) begin
        pulses++;
        if (first < 0) first = i - 1;
      end
    end
    check("held_pulses", pulses, 1);
    check("held_latency", first, 425);

    // saturating 4-bit counter: fast A must read 15, not wrap
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 0;
    while (!resp_valid2 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("sat_latency", n, 139);
    check("sat_resp", 32'(resp2), 32'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
